writeback_regfile: RTL and testbench

//  Writeback stage plus architectural register file of the 8-bit pipeline. Consumes the
//  EM/WB pipeline register outputs, selects ALU result or memory data, commits it to an
//  8-entry file, serves the two decode read ports with same-cycle write bypass, counts

---
 rtl/writeback_regfile_if.sv | 37 +++
 rtl/writeback_regfile.sv | 67 ++++++
 tb/tb_writeback_regfile.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_regfile_if.sv
// Writeback/regfile bus: EM/WB pipeline inputs, decode and debug read ports,
// and status outputs.
interface writeback_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic              regwrite_i;
    logic              write_data_control_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] q_i;
    logic [ADDR_W-1:0] write_addr_i;
    logic              done_i;
    logic [ADDR_W-1:0] rs_addr_i;
    logic [ADDR_W-1:0] rt_addr_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [DATA_W-1:0] dbg_data_o;
    logic [CNT_W-1:0]  retired_o;
    logic              halted_o;

    modport master (
        output regwrite_i, write_data_control_i, alu_result_i, q_i,
        output write_addr_i, done_i, rs_addr_i, rt_addr_i, dbg_addr_i,
        input  rs_data_o, rt_data_o, wb_data_o, dbg_data_o,
        input  retired_o, halted_o
    );

    modport slave (
        input  regwrite_i, write_data_control_i, alu_result_i, q_i,
        input  write_addr_i, done_i, rs_addr_i, rt_addr_i, dbg_addr_i,
        output rs_data_o, rt_data_o, wb_data_o, dbg_data_o,
        output retired_o, halted_o
    );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage and 8-entry architectural register file with
// same-cycle write bypass, retired-write counter and halt latch.
module writeback_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    writeback_regfile_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              we;
    logic              halted;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] rf [NREG];
    logic [CNT_W-1:0]  retired;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (bus.done_i) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        halted = (state == HALTED);
        we     = bus.regwrite_i && (state == RUN);
    end

    assign wb_data = bus.write_data_control_i ? bus.q_i : bus.alu_result_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (we) begin
            rf[bus.write_addr_i] <= wb_data;
        end
    end

    // Saturating: holds at all-ones rather than wrapping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          retired <= '0;
        else if (we && (retired != '1))     retired <= retired + 1'b1;
    end

    assign bus.wb_data_o  = wb_data;
    assign bus.rs_data_o  = (we && bus.rs_addr_i == bus.write_addr_i)
                            ? wb_data : rf[bus.rs_addr_i];
    assign bus.rt_data_o  = (we && bus.rt_addr_i == bus.write_addr_i)
                            ? wb_data : rf[bus.rt_addr_i];
    assign bus.dbg_data_o = rf[bus.dbg_addr_i];
    assign bus.retired_o  = retired;
    assign bus.halted_o   = halted;
endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile.
// Negedge monitor compares queued expectations.
module tb_writeback_regfile;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic done_sim = 1'b0;

  always #5 clk_i = ~clk_i;

  writeback_regfile_if #(
    .DATA_W(8), .ADDR_W(3), .CNT_W(16)
  ) a ();
  writeback_regfile_if #(
    .DATA_W(8), .ADDR_W(3), .CNT_W(4)
  ) b ();

  writeback_regfile #(
    .DATA_W(8), .ADDR_W(3), .CNT_W(16)
  ) dut_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (a)
  );

  writeback_regfile #(
    .DATA_W(8), .ADDR_W(3), .CNT_W(4)
  ) dut_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (b)
  );

  typedef enum {
    K_WB, K_RS, K_RT, K_DBG, K_RET, K_HALT
  } kind_e;

  typedef struct {
    int          dut;
    kind_e       kind;
    logic [15:0] exp;
    string       tag;
  } chk_t;

  chk_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void expect_v(
    int dut, kind_e k, logic [15:0] v, string tag
  );
    chk_t c;
    c.dut  = dut;
    c.kind = k;
    c.exp  = v;
    c.tag  = tag;
    sb.push_back(c);
  endfunction

  function automatic logic [15:0] actual(
    int dut, kind_e k
  );
    logic [15:0] r;
    r = '0;
    if (dut == 0) begin
      case (k)
        K_WB:    r = {8'h00, a.wb_data_o};
        K_RS:    r = {8'h00, a.rs_data_o};
        K_RT:    r = {8'h00, a.rt_data_o};
        K_DBG:   r = {8'h00, a.dbg_data_o};
        K_RET:   r = a.retired_o;
        default: r = {15'h0, a.halted_o};
      endcase
    end else begin
      case (k)
        K_WB:    r = {8'h00, b.wb_data_o};
        K_RS:    r = {8'h00, b.rs_data_o};
        K_RT:    r = {8'h00, b.rt_data_o};
        K_DBG:   r = {8'h00, b.dbg_data_o};
        K_RET:   r = {12'h000, b.retired_o};
        default: r = {15'h0, b.halted_o};
      endcase
    end
    return r;
  endfunction

  always @(negedge clk_i) begin
    chk_t        cur;
    logic [15:0] act;
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      act = actual(cur.dut, cur.kind);
      n_cmp++;
      if (act !== cur.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h",
                 cur.tag, act, cur.exp);
      end
    end
  end

  task automatic check_now(
    logic [15:0] act, logic [15:0] exp, string tag
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, act, exp);
    end
  endtask

  initial begin
    #100000;
    if (!done_sim) begin
      n_bad++;
      $display("FAIL timeout: stimulus did not finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_a(
    logic we, logic ctl, logic [7:0] alu,
    logic [7:0] q, logic [2:0] wa, logic done
  );
    a.regwrite_i           = we;
    a.write_data_control_i = ctl;
    a.alu_result_i         = alu;
    a.q_i                  = q;
    a.write_addr_i         = wa;
    a.done_i               = done;
  endtask

  task automatic read_a(
    logic [2:0] rs, logic [2:0] rt, logic [2:0] dbg
  );
    a.rs_addr_i  = rs;
    a.rt_addr_i  = rt;
    a.dbg_addr_i = dbg;
  endtask

  initial begin
    drive_a(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    read_a(3'd0, 3'd0, 3'd0);
    b.regwrite_i           = 1'b0;
    b.write_data_control_i = 1'b0;
    b.alu_result_i         = 8'h00;
    b.q_i                  = 8'h00;
    b.write_addr_i         = 3'd0;
    b.done_i               = 1'b0;
    b.rs_addr_i            = 3'd0;
    b.rt_addr_i            = 3'd0;
    b.dbg_addr_i           = 3'd0;

    tick();
    check_now({15'h0, a.halted_o}, 16'd0, "rst_halt_now");
    check_now(a.retired_o, 16'd0, "rst_ret_now");
    check_now({8'h00, a.dbg_data_o}, 16'h00, "rst_dbg_now");
    expect_v(0, K_RET, 16'd0, "rst_ret");
    expect_v(0, K_HALT, 16'd0, "rst_halt");
    expect_v(0, K_DBG, 16'h00, "rst_dbg0");
    tick();
    rst_i = 1'b0;

    tick();
    drive_a(1'b1, 1'b0, 8'h3C, 8'hEE, 3'd5, 1'b0);
    read_a(3'd0, 3'd1, 3'd5);
    expect_v(0, K_WB, 16'h3C, "alu_wb");
    expect_v(0, K_DBG, 16'h00, "alu_dbg_pre");
    tick();
    drive_a(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    expect_v(0, K_DBG, 16'h3C, "alu_dbg5");
    expect_v(0, K_RET, 16'd1, "alu_ret");

    tick();
    drive_a(1'b1, 1'b1, 8'h12, 8'hA5, 3'd2, 1'b0);
    read_a(3'd2, 3'd2, 3'd2);
    expect_v(0, K_WB, 16'hA5, "ld_wb");
    expect_v(0, K_RS, 16'hA5, "ld_rs_byp");
    expect_v(0, K_RT, 16'hA5, "ld_rt_byp");
    expect_v(0, K_DBG, 16'h00, "ld_dbg_nobyp");
    tick();
    drive_a(1'b0, 1'b0, 8'h66, 8'h5A, 3'd2, 1'b0);
    expect_v(0, K_RS, 16'hA5, "nowe_rs");
    expect_v(0, K_RT, 16'hA5, "nowe_rt");
    expect_v(0, K_WB, 16'h66, "nowe_wb");
    tick();
    drive_a(1'b1, 1'b0, 8'h77, 8'h00, 3'd2, 1'b0);
    read_a(3'd2, 3'd5, 3'd2);
    expect_v(0, K_RS, 16'h77, "mix_rs_byp");
    expect_v(0, K_RT, 16'h3C, "mix_rt_file");
    expect_v(0, K_RET, 16'd2, "mix_ret");

    for (int i = 0; i < 8; i++) begin
      tick();
      drive_a(1'b1, 1'b0, 8'(i * 17), 8'h00,
              3'(i), 1'b0);
    end
    tick();
    drive_a(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    expect_v(0, K_RET, 16'd11, "sweep_ret");
    for (int i = 0; i < 8; i++) begin
      read_a(3'(i), 3'(7 - i), 3'(i));
      expect_v(0, K_RS, 16'(8'(i * 17)),
               $sformatf("sweep_rs%0d", i));
      expect_v(0, K_RT, 16'(8'((7 - i) * 17)),
               $sformatf("sweep_rt%0d", i));
      expect_v(0, K_DBG, 16'(8'(i * 17)),
               $sformatf("sweep_dbg%0d", i));
      tick();
    end

    drive_a(1'b1, 1'b0, 8'h11, 8'h00, 3'd7, 1'b1);
    read_a(3'd7, 3'd0, 3'd7);
    expect_v(0, K_RS, 16'h11, "halt_rs_byp");
    expect_v(0, K_HALT, 16'd0, "halt_pre");
    tick();
    drive_a(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    expect_v(0, K_DBG, 16'h11, "halt_dbg7");
    expect_v(0, K_RET, 16'd12, "halt_ret");
    expect_v(0, K_HALT, 16'd1, "halt_set");
    tick();
    drive_a(1'b1, 1'b0, 8'h22, 8'h00, 3'd7, 1'b1);
    read_a(3'd7, 3'd7, 3'd7);
    expect_v(0, K_RS, 16'h11, "hlt_rs_nobyp");
    expect_v(0, K_RT, 16'h11, "hlt_rt_nobyp");
    expect_v(0, K_WB, 16'h22, "hlt_wb");
    tick();
    drive_a(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    expect_v(0, K_DBG, 16'h11, "hlt_dbg7");
    expect_v(0, K_RET, 16'd12, "hlt_ret");
    expect_v(0, K_HALT, 16'd1, "hlt_stay");

    tick();
    rst_i = 1'b1;
    drive_a(1'b1, 1'b0, 8'h99, 8'h00, 3'd3, 1'b0);
    read_a(3'd0, 3'd0, 3'd7);
    expect_v(0, K_DBG, 16'h00, "mrst_dbg7");
    expect_v(0, K_RET, 16'd0, "mrst_ret");
    expect_v(0, K_HALT, 16'd0, "mrst_halt");
    tick();
    read_a(3'd0, 3'd0, 3'd3);
    expect_v(0, K_DBG, 16'h00, "mrst_dbg3");
    tick();
    rst_i = 1'b0;
    drive_a(1'b1, 1'b0, 8'h42, 8'h00, 3'd3, 1'b0);
    read_a(3'd3, 3'd0, 3'd3);
    expect_v(0, K_RS, 16'h42, "post_rs_byp");
    expect_v(0, K_DBG, 16'h00, "post_dbg_pre");
    tick();
    drive_a(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    expect_v(0, K_DBG, 16'h42, "post_dbg3");
    expect_v(0, K_RET, 16'd1, "post_ret");

    for (int i = 0; i < 20; i++) begin
      tick();
      b.regwrite_i   = 1'b1;
      b.alu_result_i = 8'(i);
      b.write_addr_i = 3'(i % 8);
      expect_v(1, K_RET, 16'((i > 15) ? 15 : i),
               $sformatf("sat_ret%0d", i));
    end
    tick();
    b.regwrite_i = 1'b0;
    expect_v(1, K_RET, 16'd15, "sat_final");
    expect_v(1, K_HALT, 16'd0, "sat_halt");

    repeat (2) @(negedge clk_i);
    done_sim = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    if (n_bad == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end
endmodule
